// File: rtl/tb_run_pkg.sv
// Shared types for the simulation run sequencer: FSM states and run status codes.
package tb_run_pkg;

    localparam int unsigned CYC_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        STAT_NONE    = 2'd0,
        STAT_PASS    = 2'd1,
        STAT_FAIL    = 2'd2,
        STAT_TIMEOUT = 2'd3
    } run_status_e;

endpackage

// File: rtl/tb_sat_counter.sv
// Up-counter with synchronous clear that holds at a programmable limit.
module tb_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         sat_c
);

    logic [W-1:0] count_nxt;

    assign sat_c = (count == limit);

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (en && !sat_c) begin
            count_nxt = count + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/tb_run_ctrl.sv
// Run sequencer: DUT reset window, run-cycle counting, done/timeout detection,
// dump gating, trace-flush drain and a sticky finish with status.
module tb_run_ctrl
    import tb_run_pkg::*;
#(
    parameter int unsigned CYC_W        = CYC_W_DEF,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned HB_LOG2      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CYC_W-1:0] max_cycles,
    input  logic             dump_enable,
    input  logic [CYC_W-1:0] dump_start,
    input  logic [CYC_W-1:0] dump_stop,
    input  logic             dut_done,
    input  logic             dut_pass,
    output logic             dut_reset,
    output logic             running,
    output logic             dump_on,
    output logic             heartbeat,
    output logic             finish,
    output logic [1:0]       status,
    output logic [CYC_W-1:0] cycle_count
);

    localparam int unsigned TMR_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    run_state_e         state, state_nxt;
    logic [1:0]         status_nxt;
    logic               tmr_clr, tmr_en, tmr_sat;
    logic [TMR_W-1:0]   tmr_limit, tmr_cnt_unused;
    logic               cyc_clr, cyc_en, cyc_sat;
    logic               dump_nxt, hb_nxt;
    logic [HB_LOG2-1:0] hb_low_inc;

    // One timer serves both the reset window and the drain window.
    assign tmr_limit = (state == ST_RST) ? TMR_W'(RST_CYCLES - 1) : TMR_W'(DRAIN_CYCLES - 1);

    tb_sat_counter #(.W(TMR_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .count (tmr_cnt_unused),
        .sat_c (tmr_sat)
    );

    tb_sat_counter #(.W(CYC_W)) u_cycles (
        .clock (clock),
        .reset (reset),
        .clr   (cyc_clr),
        .en    (cyc_en),
        .limit ({CYC_W{1'b1}}),
        .count (cycle_count),
        .sat_c (cyc_sat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        cyc_clr    = 1'b0;
        cyc_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                cyc_clr = 1'b1;
                if (start) begin
                    state_nxt = ST_RST;
                end
            end
            ST_RST: begin
                cyc_clr = 1'b1;
                if (tmr_sat) begin
                    tmr_clr   = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RUN: begin
                tmr_clr = 1'b1;
                // A DUT result takes priority over a simultaneous timeout.
                if (dut_done) begin
                    status_nxt = dut_pass ? STAT_PASS : STAT_FAIL;
                    state_nxt  = ST_DRAIN;
                end else if ((max_cycles != '0) && (cycle_count == max_cycles - CYC_W'(1))) begin
                    status_nxt = STAT_TIMEOUT;
                    state_nxt  = ST_DRAIN;
                end else begin
                    cyc_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (tmr_sat) begin
                    state_nxt = ST_DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Dump gate uses the current count; it drops as soon as the block leaves DRAIN.
    assign dump_nxt = dump_enable
                   && (state inside {ST_RUN, ST_DRAIN})
                   && (state_nxt inside {ST_RUN, ST_DRAIN})
                   && (cycle_count >= dump_start)
                   && ((dump_stop == '0) || (cycle_count < dump_stop));

    // Heartbeat is registered, so look at the count the next cycle will show.
    assign hb_low_inc = cycle_count[HB_LOG2-1:0] + HB_LOG2'(1);
    assign hb_nxt     = cyc_en && (cyc_sat ? (&cycle_count[HB_LOG2-1:0]) : (&hb_low_inc));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dut_reset <= 1'b1;
            running   <= 1'b0;
            dump_on   <= 1'b0;
            heartbeat <= 1'b0;
            finish    <= 1'b0;
            status    <= STAT_NONE;
        end else begin
            dut_reset <= (state_nxt == ST_IDLE) || (state_nxt == ST_RST);
            running   <= (state_nxt == ST_RUN);
            dump_on   <= dump_nxt;
            heartbeat <= hb_nxt;
            finish    <= (state_nxt == ST_DONE);
            status    <= status_nxt;
        end
    end

endmodule
